// File: rtl/mac_output_drain_pkg.sv
// Shared types and constants for the MAC output drain.
package mac_package;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_READ  = 2'd1,
        DRAIN_FLUSH = 2'd2,
        DRAIN_DONE  = 2'd3
    } drain_state_t;

    localparam int MAC_DRAIN_FIFO_DEPTH = 2;

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int mac_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mac_output_drain_if.sv
// Output-memory read port plus the outgoing c_sink stream, as seen from the drain.
interface mac_output_drain_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                    mem_req_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;
    logic                    c_valid_o;
    logic [DATA_WIDTH-1:0]   c_data_o;
    logic [DATA_WIDTH/8-1:0] c_strb_o;
    logic                    c_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, c_valid_o, c_data_o, c_strb_o,
        input  mem_rdata_i, c_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, c_valid_o, c_data_o, c_strb_o,
        output mem_rdata_i, c_ready_i
    );
endinterface

// File: rtl/mac_output_drain_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is visible on data_o.
module hwpe_stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/mac_output_drain.sv
// Drains nb_words words from the output memory into the c_sink stream via a 2-entry FIFO.
//
// state        | meaning
// DRAIN_IDLE   | waiting for start_i; cnt_o holds the last drain's count
// DRAIN_READ   | issuing memory reads while FIFO credit allows
// DRAIN_FLUSH  | all reads issued; streaming out the remaining words
// DRAIN_DONE   | one-cycle done_o pulse
module mac_output_drain
    import mac_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           nb_words_i,
    mac_output_drain_if.master    bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           cnt_o
);
    localparam int CNT_W = mac_cnt_width(MAC_DRAIN_FIFO_DEPTH);
    localparam int SW    = CNT_W + 1;

    drain_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           nb_q, nb_d;
    logic [15:0]           req_cnt_q, req_cnt_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [CNT_W-1:0]      fifo_count;
    logic                  pop;
    logic                  mem_req;
    logic [SW-1:0]         slots_used;

    assign pop = fifo_valid & bus.c_ready_i;

    // Credit counts the word leaving this cycle as already gone, which is what
    // lets a 2-entry FIFO sustain one word per cycle across the read latency.
    assign slots_used = SW'(inflight_q) + SW'(fifo_count) - SW'(pop);
    assign mem_req    = (state_q == DRAIN_READ) && !clear_i
                        && (slots_used < SW'(MAC_DRAIN_FIFO_DEPTH));

    hwpe_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAC_DRAIN_FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (inflight_q),
        .data_i  (bus.mem_rdata_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        nb_d       = nb_q;
        req_cnt_d  = req_cnt_q;
        cnt_d      = cnt_q;
        inflight_d = mem_req;
        if (clear_i) begin
            state_d    = DRAIN_IDLE;
            cnt_d      = '0;
            inflight_d = 1'b0;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    if (start_i) begin
                        nb_d      = nb_words_i;
                        addr_d    = base_addr_i;
                        req_cnt_d = '0;
                        cnt_d     = '0;
                        state_d   = (nb_words_i == 16'd0) ? DRAIN_DONE : DRAIN_READ;
                    end
                end
                DRAIN_READ: begin
                    if (pop) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (mem_req) begin
                        addr_d    = addr_q + ADDR_WIDTH'(1);
                        req_cnt_d = req_cnt_q + 16'd1;
                        if ((req_cnt_q + 16'd1) == nb_q) begin
                            state_d = DRAIN_FLUSH;
                        end
                    end
                end
                DRAIN_FLUSH: begin
                    if (pop) begin
                        cnt_d = cnt_q + 16'd1;
                        if ((cnt_q + 16'd1) == nb_q) begin
                            state_d = DRAIN_DONE;
                        end
                    end
                end
                DRAIN_DONE: begin
                    state_d = DRAIN_IDLE;
                end
                default: begin
                    state_d = DRAIN_IDLE;
                end
            endcase
        end
        busy_d = (state_d != DRAIN_IDLE);
        done_d = (state_d == DRAIN_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= DRAIN_IDLE;
            addr_q     <= '0;
            nb_q       <= '0;
            req_cnt_q  <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nb_q       <= nb_d;
            req_cnt_q  <= req_cnt_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_req_o  = mem_req;
    assign bus.mem_addr_o = addr_q;
    assign bus.c_valid_o  = fifo_valid;
    assign bus.c_data_o   = fifo_valid ? fifo_data : '0;
    assign bus.c_strb_o   = {(DATA_WIDTH/8){fifo_valid}};
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign cnt_o          = cnt_q;

endmodule

// File: tb/tb_mac_output_drain.sv
// Self-checking bench for mac_output_drain: scoreboard of expected addresses/words plus directed corner cases.
module tb_mac_output_drain;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [15:0] base_addr_i;
    logic [15:0] nb_words_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] cnt_o;

    mac_output_drain_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    mac_output_drain #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .nb_words_i  (nb_words_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cnt_o       (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Memory: one-cycle read latency, returns addr+0x100; garbage when not read.
    always @(posedge clk_i) begin
        if (bus.mem_req_o) bus.mem_rdata_i <= 32'(bus.mem_addr_o) + 32'h100;
        else               bus.mem_rdata_i <= $urandom;
    end

    int ready_mode = 0;
    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       bus.c_ready_i = 1'b1;
            1:       bus.c_ready_i = ~bus.c_ready_i;
            default: bus.c_ready_i = ($urandom_range(0, 2) != 0);
        endcase
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: phase 0 idle, 1 transferring, 2 done-pulse cycle.
    int          m_phase = 0;
    int          m_cnt = 0, m_issued = 0, m_consumed = 0, m_n = 0, t_acc = 0;
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          lat_chk = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;

    task automatic model_flush();
        m_phase = 0;
        exp_addr.delete();
        exp_data.delete();
        m_cnt = 0;
        m_issued = 0;
        m_consumed = 0;
    endtask

    always @(negedge clk_i) begin
        logic hs;
        logic [15:0] a;
        if (!rst_ni) begin
            chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
            chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
            chk("rst_c_valid", 32'(bus.c_valid_o), 32'd0);
            chk("rst_c_data", bus.c_data_o, 32'd0);
            chk("rst_c_strb", 32'(bus.c_strb_o), 32'd0);
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_cnt", 32'(cnt_o), 32'd0);
            model_flush();
            prev_stall = 0;
        end else begin
            hs = bus.c_valid_o & bus.c_ready_i;
            chk("busy", 32'(busy_o), 32'(m_phase != 0));
            chk("done", 32'(done_o), 32'(m_phase == 2));
            chk("cnt", 32'(cnt_o), 32'(m_cnt));
            if (lat_chk && done_o) chk("lat_done", 32'(cyc - t_acc), 32'(m_n + 3));

            if (exp_addr.size() == 0) begin
                chk("idle_req", 32'(bus.mem_req_o), 32'd0);
            end else if (bus.mem_req_o) begin
                chk("mem_addr", 32'(bus.mem_addr_o), 32'(exp_addr.pop_front()));
                if (lat_chk) chk("lat_req", 32'(cyc - t_acc), 32'(1 + m_issued));
                m_issued++;
                chk("buffered_le_2", 32'((m_issued - (m_consumed + int'(hs))) <= 2), 32'd1);
            end

            if (prev_stall) begin
                chk("stall_valid", 32'(bus.c_valid_o), 32'd1);
                chk("stall_data", bus.c_data_o, prev_data);
            end
            if (bus.c_valid_o) chk("strb", 32'(bus.c_strb_o), 32'hF);

            if (exp_data.size() == 0) begin
                chk("idle_valid", 32'(bus.c_valid_o), 32'd0);
            end else if (hs) begin
                chk("c_data", bus.c_data_o, exp_data.pop_front());
                if (lat_chk) chk("lat_word", 32'(cyc - t_acc), 32'(3 + m_cnt));
                m_cnt++;
                m_consumed++;
            end
            prev_stall = bus.c_valid_o && !bus.c_ready_i && !clear_i;
            prev_data  = bus.c_data_o;

            if (clear_i) begin
                model_flush();
            end else begin
                case (m_phase)
                    0: if (start_i) begin
                        model_flush();
                        for (int k = 0; k < int'(nb_words_i); k++) begin
                            a = base_addr_i + 16'(k);
                            exp_addr.push_back(a);
                            exp_data.push_back(32'(a) + 32'h100);
                        end
                        t_acc   = cyc;
                        m_n     = int'(nb_words_i);
                        m_phase = (nb_words_i == 16'd0) ? 2 : 1;
                    end
                    1: if (exp_data.size() == 0) m_phase = 2;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_start(input logic [15:0] base, input logic [15:0] n);
        base_addr_i = base;
        nb_words_i  = n;
        start_i     = 1'b1;
        step(1);
        start_i     = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            if (m_phase == 0) return;
            step(1);
        end
        chk("idle_timeout", 32'(m_phase), 32'd0);
    endtask

    task automatic drain(input logic [15:0] base, input logic [15:0] n);
        do_start(base, n);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] rb;
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        nb_words_i  = '0;
        step(3);
        rst_ni = 1'b1;
        step(2);

        // Basic drain with latency/throughput timing checks.
        lat_chk = 1;
        ready_mode = 0;
        drain(16'h0010, 16'd4);
        lat_chk = 0;
        step(2);

        // Back-pressure every other cycle.
        ready_mode = 1;
        drain(16'h0010, 16'd8);
        step(2);

        ready_mode = 0;
        drain(16'h0010, 16'd0);
        step(2);

        drain(16'hFFFE, 16'd4);
        step(2);

        // Soft clear in cycle 4 of a long drain, then a normal short drain.
        do_start(16'h0020, 16'd16);
        step(3);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        step(1);
        drain(16'h0030, 16'd2);
        step(2);

        // Start and clear together: clear wins.
        base_addr_i = 16'h0077;
        nb_words_i  = 16'd3;
        start_i     = 1'b1;
        clear_i     = 1'b1;
        step(1);
        start_i     = 1'b0;
        clear_i     = 1'b0;
        step(3);

        // Repeated start while busy, then reset mid-drain, then a fresh drain.
        ready_mode = 1;
        do_start(16'h0040, 16'd10);
        step(2);
        do_start(16'h0999, 16'd3);
        step(1);
        rst_ni = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(1);
        drain(16'h0050, 16'd3);
        step(2);

        for (int r = 0; r < 30; r++) begin
            ready_mode = $urandom_range(0, 2);
            rb = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                             : 16'($urandom);
            do_start(rb, 16'($urandom_range(0, 12)));
            if ($urandom_range(0, 3) == 0) begin
                step($urandom_range(0, 6));
                if ($urandom_range(0, 1) == 0) begin
                    clear_i = 1'b1;
                    step(1);
                    clear_i = 1'b0;
                end else begin
                    do_start(16'($urandom), 16'($urandom_range(1, 5)));
                end
            end
            wait_idle();
            step($urandom_range(0, 2));
        end

        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_output_drain.md
MAC_OUTPUT_DRAIN -- requirements
Module: mac_output_drain

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: DATA_WIDTH, 32, output memory and stream word width.
REQ-003 Parameter: ADDR_WIDTH, 16, output memory word-address width.
REQ-004 Port: clk_i  in  1  clock.
REQ-005 Port: rst_ni  in  1  asynchronous active-low reset.
REQ-006 Port: clear_i  in  1  synchronous soft clear.
REQ-007 Port: start_i  in  1  one-cycle drain request.
REQ-008 Port: base_addr_i  in  ADDR_WIDTH  first word address; sampled when start_i is accepted.
REQ-009 Port: nb_words_i  in  16  word count (PANDA_OUTPUT_DATA_N); sampled when start_i is accepted.
REQ-010 Port: mem_req_o  out  1  output-memory read strobe.
REQ-011 Port: mem_addr_o  out  ADDR_WIDTH  read address.
REQ-012 Port: mem_rdata_i  in  DATA_WIDTH  read data, fixed 1-cycle latency after mem_req_o.
REQ-013 Port: c_valid_o / c_data_o / c_strb_o  out  1 / DATA_WIDTH / DATA_WIDTH/8  stream toward c_sink.
REQ-014 Port: c_ready_i  in  1  stream ready.
REQ-015 Port: busy_o  out  1  drain in progress.
REQ-016 Port: done_o  out  1  one-cycle completion pulse.
REQ-017 Port: cnt_o  out  16  words handshaken in current or last drain.

Function
REQ-018 States SHALL be IDLE, READ, FLUSH, DONE.
REQ-019 IDLE: start_i=1 with nb_words_i>0 -> READ; with nb_words_i=0 -> DONE, no memory read.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 READ: mem_req_o SHALL assert only when outstanding reads + FIFO occupancy < 2. Address base+k for k-th request, incrementing modulo 2^ADDR_WIDTH.
REQ-022 Read data SHALL be written into a 2-entry FIFO the cycle after its request. The FIFO head drives c_data_o/c_valid_o.
REQ-023 After the last request is issued -> FLUSH. FLUSH -> DONE on the handshake (c_valid_o & c_ready_i) of word nb_words.
REQ-024 DONE SHALL last one cycle with done_o=1, then IDLE.
REQ-025 Latency: start accepted at edge 0 -> mem_req_o high cycle 1 -> c_valid_o high cycle 3. With c_ready_i held high, one word per cycle sustained.
REQ-026 c_valid_o SHALL NOT drop and c_data_o SHALL NOT change while c_valid_o=1 and c_ready_i=0.
REQ-027 c_strb_o SHALL be all-ones whenever c_valid_o=1.
REQ-028 cnt_o SHALL clear on accepted start and increment per stream handshake. It SHALL hold its value in IDLE.
REQ-029 busy_o SHALL be 1 in READ, FLUSH and DONE.
REQ-030 clear_i SHALL take priority over all events and return the FSM to IDLE. It SHALL flush the FIFO, drop the in-flight read, zero cnt_o, and SHALL NOT pulse done_o.
REQ-031 start_i and clear_i in the same cycle: clear wins, start discarded.

Reset
REQ-032 On rst_ni=0 the FSM SHALL be IDLE and the FIFO empty. All outputs SHALL be 0: mem_req_o, mem_addr_o, c_valid_o, c_data_o, c_strb_o, busy_o, done_o, cnt_o.
REQ-033 Reset asserted mid-drain SHALL abort immediately with no done_o pulse; the next start SHALL behave as from power-up.

Structure
REQ-034 The state enum drain_state_t (DRAIN_IDLE, DRAIN_READ, DRAIN_FLUSH, DRAIN_DONE) SHALL reside in mac_package.
REQ-035 The constant MAC_DRAIN_FIFO_DEPTH=2 SHALL reside in mac_package.
REQ-036 The 2-entry buffer SHALL be a single sub-module instance of hwpe_stream_fifo (DEPTH=2). All control logic stays in mac_output_drain.

Verification
REQ-037 base=0x0010, n=4, c_ready_i=1, mem returns addr+0x100: words 0x110..0x113 on cycles 3..6; done_o on cycle 7; cnt_o=4.
REQ-038 n=8, c_ready_i toggling 1/0 every cycle: data in order 0x110..0x117, stable during stalls, never more than 2 reads outstanding, done_o once, cnt_o=8.
REQ-039 n=0: done_o pulses cycle 1; mem_req_o and c_valid_o never asserted.
REQ-040 base=0xFFFE, n=4: mem_addr_o sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-041 clear_i at cycle 4 of an n=16 drain: IDLE next cycle, c_valid_o=0, cnt_o=0, no done_o. A following start with n=2 completes normally.
REQ-042 rst_ni pulsed low mid-drain, plus start_i repeated while busy: all outputs 0 during reset, and the repeated start has no effect on count or addresses.
